// File: rtl/pipe_stall_ctrl_if.sv
// Control bundle between the pipeline stall scheduler and the rest of the core:
// hazard/MDU/dmem status in, pipeline register enables/flushes and status out.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ld_use_haz;
    logic             ex_redirect;
    logic             mdu_start;
    logic             mdu_done;
    logic             dmem_req;
    logic             dmem_ack;
    logic             pc_wr;
    logic             if_id_wr;
    logic             if_id_flush;
    logic             id_ex_wr;
    logic             id_ex_flush;
    logic             ex_mem_wr;
    logic             ex_mem_flush;
    logic             mem_wb_wr;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_timeout;

    // Pipeline side: supplies hazard/status, consumes the enables
    modport master (
        output ld_use_haz, ex_redirect, mdu_start, mdu_done, dmem_req, dmem_ack,
        input  pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush,
               ex_mem_wr, ex_mem_flush, mem_wb_wr, stall_cnt, mem_timeout
    );

    // Scheduler side
    modport slave (
        input  ld_use_haz, ex_redirect, mdu_start, mdu_done, dmem_req, dmem_ack,
        output pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush,
               ex_mem_wr, ex_mem_flush, mem_wb_wr, stall_cnt, mem_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline. Combines a memory wait
// (full freeze), a multi-cycle MDU hold, EX redirects and load-use bubbles into
// per-register write-enables and flushes, with a stall counter and memory timeout.
module pipe_stall_ctrl #(
    parameter int CNT_W  = 32,
    parameter int TO_W   = 8,
    parameter int MEM_TO = 200
) (
    input  logic               clk,
    input  logic               rstn,
    pipe_stall_ctrl_if.slave   bus
);

    typedef enum logic {RUN, MDU} state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TO);

    state_t            state, nxt;
    logic              done_seen;
    logic              release_mdu;
    logic [TO_W-1:0]   to_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_timeout;
    logic              mem_wait;

    logic pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush;
    logic ex_mem_wr, ex_mem_flush, mem_wb_wr;

    assign mem_wait = bus.dmem_req & ~bus.dmem_ack;

    // Next state and enables/flushes; memory wait overrides everything else
    always_comb begin
        nxt          = state;
        release_mdu  = 1'b0;
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        id_ex_wr     = 1'b1;
        ex_mem_wr    = 1'b1;
        mem_wb_wr    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (mem_wait) begin
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_wr  = 1'b0;
            ex_mem_wr = 1'b0;
            mem_wb_wr = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.mdu_start) begin
                        // Hold the MDU op in EX, bubble into MEM
                        nxt          = MDU;
                        pc_wr        = 1'b0;
                        if_id_wr     = 1'b0;
                        id_ex_wr     = 1'b0;
                        ex_mem_flush = 1'b1;
                        // Older MDU op still proceeds; the redirect squashes IF/ID
                        if (bus.ex_redirect) begin
                            pc_wr       = 1'b1;
                            if_id_wr    = 1'b1;
                            if_id_flush = 1'b1;
                        end
                    end else if (bus.ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (bus.ld_use_haz) begin
                        pc_wr       = 1'b0;
                        if_id_wr    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MDU: begin
                    if (bus.mdu_done | done_seen) begin
                        release_mdu = 1'b1;
                        nxt         = RUN;
                    end else begin
                        pc_wr        = 1'b0;
                        if_id_wr     = 1'b0;
                        id_ex_wr     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: nxt = RUN;
            endcase
        end
    end

    // State register plus the remembered MDU completion that landed during a memory wait
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            done_seen <= 1'b0;
        end else begin
            state <= nxt;
            if (release_mdu)
                done_seen <= 1'b0;
            else if (state == MDU && mem_wait && bus.mdu_done)
                done_seen <= 1'b1;
        end
    end

    // Memory-wait length tracking and sticky timeout flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_wait) begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (to_cnt >= TO_MAX - 1'b1) mem_timeout <= 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Saturating count of cycles the PC was held
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (!pc_wr && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Everything reads as disabled while reset is held
    assign bus.pc_wr        = rstn & pc_wr;
    assign bus.if_id_wr     = rstn & if_id_wr;
    assign bus.if_id_flush  = rstn & if_id_flush;
    assign bus.id_ex_wr     = rstn & id_ex_wr;
    assign bus.id_ex_flush  = rstn & id_ex_flush;
    assign bus.ex_mem_wr    = rstn & ex_mem_wr;
    assign bus.ex_mem_flush = rstn & ex_mem_flush;
    assign bus.mem_wb_wr    = rstn & mem_wb_wr;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.mem_timeout  = mem_timeout;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus a random run, checked
// against an expected-value queue filled from a behavioural model.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(32)) if0 ();
    pipe_stall_ctrl_if #(.CNT_W(3))  if1 ();

    // Narrow-counter copy shares the stimulus to exercise saturation
    assign if1.ld_use_haz  = if0.ld_use_haz;
    assign if1.ex_redirect = if0.ex_redirect;
    assign if1.mdu_start   = if0.mdu_start;
    assign if1.mdu_done    = if0.mdu_done;
    assign if1.dmem_req    = if0.dmem_req;
    assign if1.dmem_ack    = if0.dmem_ack;

    pipe_stall_ctrl #(.CNT_W(32), .TO_W(8), .MEM_TO(4)) u_dut  (.clk(clk), .rstn(rstn), .bus(if0));
    pipe_stall_ctrl #(.CNT_W(3),  .TO_W(8), .MEM_TO(4)) u_dut3 (.clk(clk), .rstn(rstn), .bus(if1));

    // {pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr, ex_mem_flush, mem_wb_wr}
    localparam logic [7:0] C_ALL   = 8'b1101_0101;
    localparam logic [7:0] C_HOLD  = 8'b0000_0111;
    localparam logic [7:0] C_MDURD = 8'b1110_0111;
    localparam logic [7:0] C_REDIR = 8'b1111_1101;
    localparam logic [7:0] C_LDUSE = 8'b0001_1101;
    localparam logic [7:0] C_FRZ   = 8'b0000_0000;

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] cnt;
        logic [2:0]  cnt3;
        logic        tout;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state
    logic        m_mdu, m_done, m_tout;
    int          m_to;
    logic [31:0] m_cnt;
    logic [2:0]  m_cnt3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_ctrl(input logic lu, rd, ms, md, rq, ak);
        if (!rstn)            return 8'h00;
        if (rq && !ak)        return C_FRZ;
        if (m_mdu)            return (md || m_done) ? C_ALL : C_HOLD;
        if (ms)               return rd ? C_MDURD : C_HOLD;
        if (rd)               return C_REDIR;
        if (lu)               return C_LDUSE;
        return C_ALL;
    endfunction

    task automatic model_reset();
        m_mdu = 0; m_done = 0; m_tout = 0; m_to = 0; m_cnt = 0; m_cnt3 = 0;
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {if0.pc_wr, if0.if_id_wr, if0.if_id_flush, if0.id_ex_wr,
                if0.id_ex_flush, if0.ex_mem_wr, if0.ex_mem_flush, if0.mem_wb_wr};
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        e = q.pop_front();
        chk({tag, ".ctrl"}, {24'h0, dut_ctrl()}, {24'h0, e.ctrl});
        chk({tag, ".cnt"},  if0.stall_cnt, e.cnt);
        chk({tag, ".cnt3"}, {29'h0, if1.stall_cnt}, {29'h0, e.cnt3});
        chk({tag, ".tout"}, {31'h0, if0.mem_timeout}, {31'h0, e.tout});
    endtask

    // One clock: entered just after a rising edge, leaves just after the next
    task automatic step(input string tag, input logic lu, rd, ms, md, rq, ak);
        exp_t e;
        logic mw;
        if0.ld_use_haz = lu; if0.ex_redirect = rd; if0.mdu_start = ms;
        if0.mdu_done = md;   if0.dmem_req = rq;    if0.dmem_ack = ak;
        e.ctrl = model_ctrl(lu, rd, ms, md, rq, ak);
        e.cnt = m_cnt; e.cnt3 = m_cnt3; e.tout = m_tout;
        q.push_back(e);
        @(negedge clk);
        compare(tag);
        mw = rq & ~ak;
        if (!e.ctrl[7]) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (m_cnt3 != 3'd7) m_cnt3++;
        end
        if (mw) begin
            if (m_to < 4) m_to++;
            if (m_to >= 4) m_tout = 1;
            if (m_mdu && md) m_done = 1;
        end else begin
            m_to = 0;
            if (m_mdu) begin
                if (md || m_done) begin m_mdu = 0; m_done = 0; end
            end else if (ms) begin
                m_mdu = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        rstn = 1'b0;
        model_reset();
        e.ctrl = 8'h00; e.cnt = 0; e.cnt3 = 0; e.tout = 0;
        q.push_back(e);
        #2;
        compare(tag);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        if0.ld_use_haz = 0; if0.ex_redirect = 0; if0.mdu_start = 0;
        if0.mdu_done = 0;   if0.dmem_req = 0;    if0.dmem_ack = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset("rst0");
        step("idle", 0,0,0,0,0,0);

        // Load-use: one bubble, one stall cycle
        step("lduse", 1,0,0,0,0,0);
        step("lduse_after", 0,0,0,0,0,0);

        // Redirect wins over load-use, no stall
        step("redir_lu", 1,1,0,0,0,0);
        step("redir_after", 0,0,0,0,0,0);

        // MDU: start, four holds, done releases
        step("mdu_start", 0,0,1,0,0,0);
        for (int i = 0; i < 4; i++) step("mdu_hold", 0,1,0,0,0,0);
        step("mdu_rel", 1,0,0,1,0,0);
        step("mdu_after", 0,0,0,0,0,0);

        // MDU with redirect in the start cycle
        step("mdu_redir", 0,1,1,0,0,0);
        step("mdu_rel2", 0,0,0,1,0,0);

        // MDU done arrives inside a memory wait, release on the ack
        step("mw_start", 0,0,1,0,0,0);
        step("mw_hold", 0,0,0,0,0,0);
        step("mw_frz0", 0,0,0,0,1,0);
        step("mw_frz1", 0,0,0,1,1,0);
        step("mw_frz2", 0,0,0,0,1,0);
        step("mw_ack", 0,0,0,0,1,1);
        step("mw_after", 0,0,0,0,0,0);

        // Memory timeout: sticky after the fourth wait edge
        for (int i = 0; i < 6; i++) step("to_wait", 0,0,0,0,1,0);
        step("to_ack", 0,0,0,0,1,1);
        step("to_sticky", 0,0,0,0,0,0);
        step("to_sticky2", 1,0,0,0,0,0);

        // Reset mid-MDU with a pending done
        step("rst_mdu", 0,0,1,0,0,0);
        step("rst_pend", 0,0,0,1,1,0);
        do_reset("rst_mid");
        step("rst_idle", 0,0,0,0,0,0);
        step("rst_noresidue", 0,0,0,0,0,0);

        // Saturation on the 3-bit copy
        for (int i = 0; i < 9; i++) step("sat", 1,0,0,0,0,0);
        step("sat_hold", 0,0,0,0,0,0);

        // Random mix
        for (int i = 0; i < 300; i++)
            step("rand", $urandom_range(0,3) == 0, $urandom_range(0,7) == 0,
                 $urandom_range(0,7) == 0, $urandom_range(0,5) == 0,
                 $urandom_range(0,3) == 0, $urandom_range(0,1) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
